// File: rtl/adsr_param_calc.sv
// Converts ADSR times (ms) and sustain level into Q1.31 step values and a sustain cycle count.
// Fixed 97-cycle latency from start to done; one shared restoring divider runs three divisions back to back.
module adsr_param_calc #(
    parameter int unsigned CYC_PER_MS = 100000,
    parameter int unsigned MS_W       = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mute,
    input  logic [MS_W-1:0] attack_ms,
    input  logic [MS_W-1:0] decay_ms,
    input  logic [MS_W-1:0] sustain_ms,
    input  logic [MS_W-1:0] release_ms,
    input  logic [15:0]     sustain_lvl,
    output logic            busy,
    output logic            done,
    output logic [31:0]     attack_step_value,
    output logic [31:0]     decay_step_value,
    output logic [31:0]     sustain_level,
    output logic [31:0]     release_step_value,
    output logic [31:0]     sustain_time
);

    typedef enum logic [2:0] {
        IDLE, MUL, DIV_A, DIV_D, DIV_R, DONE
    } state_t;

    localparam logic [31:0] ONE_Q31 = 32'h8000_0000;

    state_t state_q, state_d;

    logic [MS_W-1:0] a_ms_q, d_ms_q, s_ms_q, r_ms_q;
    logic [15:0]     lvl_q;
    logic            mute_q;

    logic [31:0] cyc_d_q, cyc_r_q, cyc_s_q, sus31_q;
    logic [31:0] res_a_q, res_d_q;

    logic [31:0] rem_q, dq_q, dvs_q;
    logic [4:0]  cnt_q;

    logic [31:0] attack_q, decay_q, level_q, release_q, stime_q;

    function automatic logic [31:0] ms_to_cyc(input logic [MS_W-1:0] ms);
        logic [47:0] p;
        p = 48'(ms) * 48'(CYC_PER_MS);
        return (p[47:32] != 16'h0) ? 32'hFFFF_FFFF : p[31:0];
    endfunction

    function automatic logic [31:0] at_least_one(input logic [31:0] q);
        return (q == 32'h0) ? 32'h1 : q;
    endfunction

    logic [31:0] sus31_c, cyc_a_c;
    logic [32:0] trial, rem_nxt;
    logic        q_bit, div_last;
    logic [31:0] quot;
    logic [31:0] attack_fin, decay_fin, release_fin;

    always_comb begin
        sus31_c  = (lvl_q > 16'h8000) ? ONE_Q31 : {lvl_q, 16'h0};
        cyc_a_c  = ms_to_cyc(a_ms_q);
        // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
        trial    = {rem_q, dq_q[31]};
        q_bit    = (trial >= {1'b0, dvs_q});
        rem_nxt  = q_bit ? (trial - {1'b0, dvs_q}) : trial;
        quot     = {dq_q[30:0], q_bit};
        div_last = (cnt_q == 5'd31);

        attack_fin  = mute_q ? 32'h0 :
                      (a_ms_q == '0) ? 32'hFFFF_FFFF : at_least_one(res_a_q);
        decay_fin   = (sus31_q == ONE_Q31) ? 32'h0 :
                      (d_ms_q == '0) ? ONE_Q31 : at_least_one(res_d_q);
        release_fin = (sus31_q == 32'h0) ? 32'h0 :
                      (r_ms_q == '0) ? ONE_Q31 : at_least_one(quot);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MUL;
            MUL:     state_d = DIV_A;
            DIV_A:   if (div_last) state_d = DIV_D;
            DIV_D:   if (div_last) state_d = DIV_R;
            DIV_R:   if (div_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == MUL) || (state_q == DIV_A) ||
               (state_q == DIV_D) || (state_q == DIV_R);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_ms_q    <= '0;
            d_ms_q    <= '0;
            s_ms_q    <= '0;
            r_ms_q    <= '0;
            lvl_q     <= '0;
            mute_q    <= 1'b0;
            cyc_d_q   <= '0;
            cyc_r_q   <= '0;
            cyc_s_q   <= '0;
            sus31_q   <= '0;
            res_a_q   <= '0;
            res_d_q   <= '0;
            rem_q     <= '0;
            dq_q      <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            attack_q  <= '0;
            decay_q   <= '0;
            level_q   <= '0;
            release_q <= '0;
            stime_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_ms_q <= attack_ms;
                        d_ms_q <= decay_ms;
                        s_ms_q <= sustain_ms;
                        r_ms_q <= release_ms;
                        lvl_q  <= sustain_lvl;
                        mute_q <= mute;
                    end
                end
                MUL: begin
                    cyc_d_q <= ms_to_cyc(d_ms_q);
                    cyc_r_q <= ms_to_cyc(r_ms_q);
                    cyc_s_q <= ms_to_cyc(s_ms_q);
                    sus31_q <= sus31_c;
                    rem_q   <= '0;
                    dq_q    <= ONE_Q31;
                    dvs_q   <= cyc_a_c;
                    cnt_q   <= '0;
                end
                DIV_A, DIV_D, DIV_R: begin
                    rem_q <= rem_nxt[31:0];
                    dq_q  <= quot;
                    cnt_q <= cnt_q + 5'd1;
                    if (div_last) begin
                        rem_q <= '0;
                        cnt_q <= '0;
                        if (state_q == DIV_A) begin
                            res_a_q <= quot;
                            dq_q    <= ONE_Q31 - sus31_q;
                            dvs_q   <= cyc_d_q;
                        end else if (state_q == DIV_D) begin
                            res_d_q <= quot;
                            dq_q    <= sus31_q;
                            dvs_q   <= cyc_r_q;
                        end else begin
                            attack_q  <= attack_fin;
                            decay_q   <= decay_fin;
                            level_q   <= sus31_q;
                            release_q <= release_fin;
                            stime_q   <= cyc_s_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign attack_step_value  = attack_q;
    assign decay_step_value   = decay_q;
    assign sustain_level      = level_q;
    assign release_step_value = release_q;
    assign sustain_time       = stime_q;

endmodule

// File: tb/tb_adsr_param_calc.sv
// Directed and randomized requests against a plain-arithmetic model of the ADSR parameter conversion.
module tb_adsr_param_calc;

    logic        clk = 1'b0;
    logic        reset, start, mute;
    logic [15:0] attack_ms, decay_ms, sustain_ms, release_ms, sustain_lvl;
    logic        busy, done;
    logic [31:0] attack_step_value, decay_step_value, sustain_level;
    logic [31:0] release_step_value, sustain_time;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic [31:0] a, d, l, r, s;
    } res_t;

    res_t cur_exp = '0;

    adsr_param_calc dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .mute               (mute),
        .attack_ms          (attack_ms),
        .decay_ms           (decay_ms),
        .sustain_ms         (sustain_ms),
        .release_ms         (release_ms),
        .sustain_lvl        (sustain_lvl),
        .busy               (busy),
        .done               (done),
        .attack_step_value  (attack_step_value),
        .decay_step_value   (decay_step_value),
        .sustain_level      (sustain_level),
        .release_step_value (release_step_value),
        .sustain_time       (sustain_time)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    function automatic longint unsigned cyc(input logic [15:0] ms);
        longint unsigned p;
        p = longint'(ms) * 64'd100000;
        return (p >= 64'h1_0000_0000) ? 64'hFFFF_FFFF : p;
    endfunction

    function automatic longint unsigned div_nz(input longint unsigned n, input longint unsigned dv);
        longint unsigned q;
        q = n / dv;
        return (n != 0 && q == 0) ? 64'd1 : q;
    endfunction

    function automatic res_t model(input logic [15:0] a, d, s, r, lvl, input logic m);
        res_t e;
        longint unsigned sus;
        sus = (lvl > 16'h8000) ? 64'h8000_0000 : (longint'(lvl) * 65536);
        e.l = 32'(sus);
        e.s = 32'(cyc(s));
        if (m)           e.a = 32'h0;
        else if (a == 0) e.a = 32'hFFFF_FFFF;
        else             e.a = 32'(div_nz(64'h8000_0000, cyc(a)));
        if (sus == 64'h8000_0000) e.d = 32'h0;
        else if (d == 0)          e.d = 32'h8000_0000;
        else                      e.d = 32'(div_nz(64'h8000_0000 - sus, cyc(d)));
        if (sus == 0)    e.r = 32'h0;
        else if (r == 0) e.r = 32'h8000_0000;
        else             e.r = 32'(div_nz(sus, cyc(r)));
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input res_t e);
        chk({tag, "_attack"},  attack_step_value,  e.a);
        chk({tag, "_decay"},   decay_step_value,   e.d);
        chk({tag, "_level"},   sustain_level,      e.l);
        chk({tag, "_release"}, release_step_value, e.r);
        chk({tag, "_stime"},   sustain_time,       e.s);
    endtask

    // inject_at > 0 pulses a second start and scrambles inputs at that cycle of the computation.
    task automatic run_req(input string tag, input logic [15:0] a, d, s, r, lvl,
                           input logic m, input int inject_at);
        res_t e;
        int lat, d0;
        e = model(a, d, s, r, lvl, m);
        attack_ms = a; decay_ms = d; sustain_ms = s; release_ms = r;
        sustain_lvl = lvl; mute = m;
        d0 = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (inject_at > 0 && n == inject_at) begin
                start = 1'b1;
                attack_ms = 16'($urandom); decay_ms = 16'($urandom);
                sustain_ms = 16'($urandom); release_ms = 16'($urandom);
                sustain_lvl = 16'($urandom); mute = ~m;
            end
            if (inject_at > 0 && n == inject_at + 1) start = 1'b0;
            if (n == 96) chk({tag, "_hold_before_done"}, attack_step_value, cur_exp.a);
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'd97);
        chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        chk_outputs(tag, e);
        @(posedge clk); #1;
        chk({tag, "_done_pulse_end"}, {31'b0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        chk_outputs({tag, "_held"}, e);
        cur_exp = e;
    endtask

    initial begin
        int d0;
        logic [15:0] v[5];
        reset = 1'b1; start = 1'b0; mute = 1'b0;
        attack_ms = '0; decay_ms = '0; sustain_ms = '0; release_ms = '0; sustain_lvl = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk_outputs("reset", '0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("idle", '0);

        run_req("nominal", 16'd10, 16'd20, 16'd100, 16'd5, 16'h4000, 1'b0, 0);
        chk("nominal_attack_const", attack_step_value, 32'd2147);
        chk("nominal_decay_const", decay_step_value, 32'd536);
        chk("nominal_stime_const", sustain_time, 32'h0098_9680);

        run_req("bypass", 16'd0, 16'd0, 16'd3, 16'd0, 16'hFFFF, 1'b0, 0);
        chk("bypass_attack_const", attack_step_value, 32'hFFFF_FFFF);
        chk("bypass_release_const", release_step_value, 32'h8000_0000);

        run_req("mute_sat", 16'd0, 16'd7, 16'd65535, 16'd65535, 16'h0001, 1'b1, 0);
        chk("mute_release_forced", release_step_value, 32'd1);
        chk("mute_stime_sat", sustain_time, 32'hFFFF_FFFF);

        run_req("busy_ignore", 16'd3, 16'd9, 16'd1, 16'd250, 16'h6000, 1'b0, 40);

        // Abort mid-computation.
        attack_ms = 16'd12; decay_ms = 16'd34; sustain_ms = 16'd56;
        release_ms = 16'd78; sustain_lvl = 16'h1234; mute = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk_outputs("abort", '0);
        #2;
        reset = 1'b0;
        repeat (110) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        cur_exp = '0;
        run_req("after_abort", 16'd12, 16'd34, 16'd56, 16'd78, 16'h1234, 1'b0, 0);

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 5; k++) begin
                case ($urandom_range(0, 5))
                    0:       v[k] = 16'd0;
                    1:       v[k] = 16'hFFFF;
                    2:       v[k] = 16'h8000;
                    3:       v[k] = 16'($urandom_range(1, 20));
                    default: v[k] = 16'($urandom);
                endcase
            end
            run_req($sformatf("rand%0d", i), v[0], v[1], v[2], v[3], v[4],
                    ($urandom_range(0, 3) == 0), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
